// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking gate arbiter.
package parking_pkg;

    localparam int unsigned LANES             = 2;
    localparam int unsigned CAPACITY_DEF      = 8;
    localparam int unsigned OPEN_TIMEOUT_DEF  = 16;
    localparam int unsigned MOTION_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        OPENING,
        OPEN,
        CLOSING
    } gate_state_e;

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Lane handshake, sensor and barrier/status signals of the parking gate.
interface parking_gate_arbiter_if
#(
    parameter int unsigned CAPACITY = parking_pkg::CAPACITY_DEF
) ();

    logic [parking_pkg::LANES-1:0] req;
    logic [parking_pkg::LANES-1:0] ack;
    logic                          pass_sensor;
    logic                          exit_pulse;
    logic                          motor_open;
    logic                          motor_close;
    logic                          gate_busy;
    logic                          lot_full;
    logic [$clog2(CAPACITY+1)-1:0] occupancy;
    logic                          timeout_err;

    modport master (
        output req, pass_sensor, exit_pulse,
        input  ack, motor_open, motor_close, gate_busy, lot_full, occupancy, timeout_err
    );

    modport slave (
        input  req, pass_sensor, exit_pulse,
        output ack, motor_open, motor_close, gate_busy, lot_full, occupancy, timeout_err
    );

endinterface

// File: rtl/parking_rr_arb2.sv
// Two-lane round-robin arbiter; pointer remembers the lane granted last.
module parking_rr_arb2
    import parking_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] req_i,
    input  logic             update_i,
    output logic [LANES-1:0] grant_o
);

    logic last_q;

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_q ? 2'b01 : 2'b10;
        end
    end

    // Reset points at lane 1 so lane 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update_i && (grant_o != '0)) begin
            last_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Parking barrier controller: lane arbitration, gate sequencing, occupancy count.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY      = CAPACITY_DEF,
    parameter int unsigned OPEN_TIMEOUT  = OPEN_TIMEOUT_DEF,
    parameter int unsigned MOTION_CYCLES = MOTION_CYCLES_DEF
)
(
    input  logic                   clk,
    input  logic                   rst,
    parking_gate_arbiter_if.slave  bus
);

    localparam int unsigned OW   = $clog2(CAPACITY + 1);
    localparam int unsigned TMAX = (OPEN_TIMEOUT > MOTION_CYCLES) ? OPEN_TIMEOUT : MOTION_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] MOTION_LAST = TW'(MOTION_CYCLES - 1);
    localparam logic [TW-1:0] OPEN_LAST   = TW'(OPEN_TIMEOUT - 1);
    localparam logic [OW-1:0] OCC_FULL    = OW'(CAPACITY);

    gate_state_e      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [LANES-1:0] ack_q, ack_d, grant;
    logic             grant_take;
    logic             timeout_q, timeout_d;
    logic             motor_open_q, motor_close_q, gate_busy_q, lot_full_q;
    logic             car_in;

    parking_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (bus.req),
        .update_i (grant_take),
        .grant_o  (grant)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 1'b1;
        ack_d      = '0;
        timeout_d  = 1'b0;
        grant_take = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if ((bus.req != '0) && !lot_full_q) begin
                    ack_d      = grant;
                    grant_take = 1'b1;
                    state_d    = OPENING;
                end
            end
            OPENING: begin
                if (timer_q == MOTION_LAST) begin
                    state_d = OPEN;
                    timer_d = '0;
                end
            end
            OPEN: begin
                if (bus.pass_sensor) begin
                    state_d = CLOSING;
                    timer_d = '0;
                end else if (timer_q == OPEN_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = CLOSING;
                    timer_d   = '0;
                end
            end
            CLOSING: begin
                if (timer_q == MOTION_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // A car entering and one leaving in the same cycle cancel out.
    assign car_in = (state_q == OPEN) && bus.pass_sensor;

    always_comb begin
        occ_d = occ_q;
        if (car_in) begin
            if (!bus.exit_pulse) begin
                occ_d = occ_q + 1'b1;
            end
        end else if (bus.exit_pulse && (occ_q != '0)) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // Outputs decode the next state so they line up with the registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            occ_q         <= '0;
            ack_q         <= '0;
            timeout_q     <= 1'b0;
            motor_open_q  <= 1'b0;
            motor_close_q <= 1'b0;
            gate_busy_q   <= 1'b0;
            lot_full_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            occ_q         <= occ_d;
            ack_q         <= ack_d;
            timeout_q     <= timeout_d;
            motor_open_q  <= (state_d == OPENING);
            motor_close_q <= (state_d == CLOSING);
            gate_busy_q   <= (state_d != IDLE);
            lot_full_q    <= (occ_d == OCC_FULL);
        end
    end

    assign bus.ack         = ack_q;
    assign bus.motor_open  = motor_open_q;
    assign bus.motor_close = motor_close_q;
    assign bus.gate_busy   = gate_busy_q;
    assign bus.lot_full    = lot_full_q;
    assign bus.occupancy   = occ_q;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter with hand-computed expectations.
module tb_parking_gate_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   exp_occ;
    logic [1:0] got_ack;

    parking_gate_arbiter_if #(.CAPACITY(8)) bus ();

    parking_gate_arbiter #(
        .CAPACITY      (8),
        .OPEN_TIMEOUT  (16),
        .MOTION_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(output logic [1:0] got);
        logic seen;
        seen = 1'b0;
        got  = '0;
        for (int i = 0; i < 40; i++) begin
            if (!seen) begin
                step(1);
                if (bus.ack != '0) begin
                    seen = 1'b1;
                    got  = bus.ack;
                end
            end
        end
        if (!seen) check("ack_wait", 32'd0, 32'd1);
    endtask

    task automatic car_in(input int lane);
        bus.req = 2'b01 << lane;
        wait_ack(got_ack);
        check("car_ack", {30'd0, got_ack}, 32'(2'b01 << lane));
        bus.req = '0;
        step(4);
        bus.pass_sensor = 1'b1;
        step(1);
        bus.pass_sensor = 1'b0;
        exp_occ++;
        check("car_occ", 32'(bus.occupancy), 32'(exp_occ));
        step(4);
        check("car_idle", 32'(bus.gate_busy), 32'd0);
    endtask

    always @(negedge clk) begin
        check("motor_excl", 32'(bus.motor_open & bus.motor_close), 32'd0);
        check("ack_onehot", 32'($onehot0(bus.ack)), 32'd1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks        = 0;
        n_err           = 0;
        exp_occ         = 0;
        rst             = 1'b1;
        bus.req         = '0;
        bus.pass_sensor = 1'b0;
        bus.exit_pulse  = 1'b0;
        step(2);
        check("rst_ack",  32'(bus.ack), 32'd0);
        check("rst_busy", 32'(bus.gate_busy), 32'd0);
        check("rst_occ",  32'(bus.occupancy), 32'd0);
        check("rst_full", 32'(bus.lot_full), 32'd0);
        rst = 1'b0;

        // Tie after reset: lane 0 first, lane 1 on the following idle cycle.
        bus.req = 2'b11;
        step(1);
        check("tie_ack0", 32'(bus.ack), 32'h1);
        bus.req = 2'b10;
        for (int i = 0; i < 4; i++) begin
            check("open_motor", 32'(bus.motor_open), 32'd1);
            step(1);
        end
        check("open_done", 32'(bus.motor_open), 32'd0);
        bus.pass_sensor = 1'b1;
        step(1);
        bus.pass_sensor = 1'b0;
        exp_occ = 1;
        check("pass_occ", 32'(bus.occupancy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("close_motor", 32'(bus.motor_close), 32'd1);
            step(1);
        end
        check("close_done", 32'(bus.motor_close), 32'd0);
        check("idle_busy",  32'(bus.gate_busy), 32'd0);
        check("idle_ack",   32'(bus.ack), 32'd0);
        step(1);
        check("tie_ack1", 32'(bus.ack), 32'h2);

        // Timeout with a stray pass_sensor during OPENING.
        bus.req = '0;
        bus.pass_sensor = 1'b1;
        step(1);
        bus.pass_sensor = 1'b0;
        step(3);
        check("to_open_busy",  32'(bus.gate_busy), 32'd1);
        check("to_open_motor", 32'(bus.motor_open), 32'd0);
        check("to_stray_occ",  32'(bus.occupancy), 32'd1);
        step(15);
        check("to_early", 32'(bus.timeout_err), 32'd0);
        check("to_early_close", 32'(bus.motor_close), 32'd0);
        step(1);
        check("to_pulse", 32'(bus.timeout_err), 32'd1);
        check("to_close", 32'(bus.motor_close), 32'd1);
        check("to_occ",   32'(bus.occupancy), 32'd1);
        step(1);
        check("to_clear", 32'(bus.timeout_err), 32'd0);
        step(2);
        check("to_close_last", 32'(bus.motor_close), 32'd1);
        step(1);
        check("to_close_done", 32'(bus.motor_close), 32'd0);
        check("to_idle", 32'(bus.gate_busy), 32'd0);

        // Fill the lot.
        for (int i = 0; i < 7; i++) car_in(i % 2);
        check("full_occ",  32'(bus.occupancy), 32'd8);
        check("full_flag", 32'(bus.lot_full), 32'd1);
        bus.req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("full_noack", 32'(bus.ack), 32'd0);
        end
        bus.exit_pulse = 1'b1;
        step(1);
        bus.exit_pulse = 1'b0;
        check("exit_occ",   32'(bus.occupancy), 32'd7);
        check("exit_full",  32'(bus.lot_full), 32'd0);
        check("exit_noack", 32'(bus.ack), 32'd0);
        step(1);
        check("exit_ack", 32'(bus.ack), 32'h1);

        // Exits during OPENING, then simultaneous pass and exit at 3.
        bus.req = '0;
        bus.exit_pulse = 1'b1;
        step(4);
        check("drain_occ",  32'(bus.occupancy), 32'd3);
        check("drain_busy", 32'(bus.gate_busy), 32'd1);
        bus.pass_sensor = 1'b1;
        step(1);
        bus.pass_sensor = 1'b0;
        bus.exit_pulse  = 1'b0;
        check("both_occ",   32'(bus.occupancy), 32'd3);
        check("both_close", 32'(bus.motor_close), 32'd1);
        step(4);
        check("both_idle", 32'(bus.gate_busy), 32'd0);
        bus.exit_pulse = 1'b1;
        step(4);
        bus.exit_pulse = 1'b0;
        check("zero_occ", 32'(bus.occupancy), 32'd0);
        step(1);
        check("zero_hold", 32'(bus.occupancy), 32'd0);
        exp_occ = 0;

        // Reset while the barrier is up.
        car_in(1);
        bus.req = 2'b01;
        step(1);
        check("pre_rst_ack", 32'(bus.ack), 32'h1);
        bus.req = '0;
        step(4);
        check("pre_rst_busy", 32'(bus.gate_busy), 32'd1);
        check("pre_rst_occ",  32'(bus.occupancy), 32'd1);
        rst = 1'b1;
        step(1);
        check("ab_ack",   32'(bus.ack), 32'd0);
        check("ab_open",  32'(bus.motor_open), 32'd0);
        check("ab_close", 32'(bus.motor_close), 32'd0);
        check("ab_busy",  32'(bus.gate_busy), 32'd0);
        check("ab_full",  32'(bus.lot_full), 32'd0);
        check("ab_to",    32'(bus.timeout_err), 32'd0);
        check("ab_occ",   32'(bus.occupancy), 32'd0);
        rst = 1'b0;
        bus.req = 2'b11;
        step(1);
        check("ab_tie", 32'(bus.ack), 32'h1);
        bus.req = '0;
        step(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 Parameters SHALL be: CAPACITY, default 8, lot capacity in cars; OPEN_TIMEOUT, default 16, maximum cycles the gate stays open waiting for a car; MOTION_CYCLES, default 4, cycles of barrier motor travel.
REQ-002 Port clk SHALL be: input, 1 bit, rising-edge clock.
REQ-003 Port rst SHALL be: input, 1 bit, synchronous active-high reset.
REQ-004 Port req SHALL be: input, 2 bits, per-lane level request from an authorized PIN controller, held until ack.
REQ-005 Port ack SHALL be: output, 2 bits, one-hot one-cycle grant pulse to the winning lane.
REQ-006 Port pass_sensor SHALL be: input, 1 bit, car fully through the barrier.
REQ-007 Port exit_pulse SHALL be: input, 1 bit, one car left the lot.
REQ-008 Ports motor_open and motor_close SHALL be: outputs, 1 bit each, barrier drive commands.
REQ-009 Port gate_busy SHALL be: output, 1 bit, high in any state other than IDLE.
REQ-010 Port lot_full SHALL be: output, 1 bit, high when occupancy == CAPACITY.
REQ-011 Port occupancy SHALL be: output, $clog2(CAPACITY+1) bits, current car count.
REQ-012 Port timeout_err SHALL be: output, 1 bit, one-cycle pulse when the open window expires with no car.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM states SHALL be IDLE, OPENING, OPEN and CLOSING.
REQ-015 In IDLE, with req != 0 and !lot_full, the block SHALL pulse ack for the winner in the next cycle and enter OPENING.
REQ-016 In IDLE with lot_full, the block SHALL issue no ack and SHALL leave requests pending.
REQ-017 Arbitration SHALL be round-robin: the lane not granted last wins when both lanes request; a single requester always wins.
REQ-018 OPENING SHALL hold motor_open=1 for exactly MOTION_CYCLES cycles, then enter OPEN.
REQ-019 In OPEN, pass_sensor=1 SHALL increment occupancy by 1 and enter CLOSING.
REQ-020 In OPEN, the timer SHALL count cycles; on reaching OPEN_TIMEOUT without pass_sensor, the block SHALL pulse timeout_err and enter CLOSING with occupancy unchanged.
REQ-021 pass_sensor outside OPEN SHALL be ignored.
REQ-022 CLOSING SHALL hold motor_close=1 for exactly MOTION_CYCLES cycles, then enter IDLE.
REQ-023 motor_open and motor_close SHALL never be high together.
REQ-024 exit_pulse SHALL decrement occupancy in any state when occupancy > 0; at 0 it SHALL be ignored, with no wrap.
REQ-025 When pass_sensor (in OPEN) and exit_pulse occur in the same cycle, occupancy SHALL be unchanged.
REQ-026 Occupancy SHALL never exceed CAPACITY, because grants are blocked when full and only one car passes per open cycle.

Reset
REQ-027 rst SHALL force IDLE, occupancy=0, the timer to 0, and ack, motor_open, motor_close, gate_busy, lot_full and timeout_err to 0.
REQ-028 Reset SHALL set the last-grant pointer to lane 1, so lane 0 wins the first tie.
REQ-029 rst asserted mid-operation (including OPEN with the barrier up) SHALL abort to IDLE on the next edge without issuing motor_close.

Structure
REQ-030 Package parking_pkg SHALL hold the FSM state enum, the default CAPACITY, OPEN_TIMEOUT and MOTION_CYCLES values, and the lane-count constant (2).
REQ-031 One sub-module, parking_rr_arb2 (2-way round-robin arbiter: req, update, one-hot grant), SHALL be instantiated; the timer and occupancy logic SHALL stay in the top module.

Verification
REQ-032 Both lanes request at the same cycle after reset -> ack=01, 4 cycles motor_open, pass_sensor -> occupancy 1, 4 cycles motor_close, then ack=10 on the next IDLE cycle.
REQ-033 Single grant with no pass_sensor -> timeout_err pulse exactly 16 cycles after entering OPEN, occupancy unchanged, closing sequence runs.
REQ-034 Fill to 8 cars -> lot_full=1, a pending req receives no ack; one exit_pulse -> occupancy 7, ack issued on the next cycle.
REQ-035 pass_sensor and exit_pulse in the same cycle at occupancy 3 -> occupancy stays 3; exit_pulse at occupancy 0 -> stays 0.
REQ-036 rst asserted during OPEN -> IDLE next cycle, all outputs 0, occupancy 0, and the next tie is won by lane 0.
REQ-037 Every cycle of every test SHALL check that motor_open and motor_close are never both high, and that ack is zero or one-hot.
